// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiply result sink.
package mm_pkg;

    localparam int DATA_W  = 12;
    localparam int DEPTH   = 16;
    localparam int ADDR_W  = $clog2(DEPTH);
    localparam int PTR_W   = $clog2(DEPTH + 1);
    localparam int GEO_W   = 5;
    localparam int CKSUM_W = 16;

    // Multiplier error code bits.
    localparam logic [1:0] EP_M1_RAGGED = 2'b01;
    localparam logic [1:0] EP_M2_BAD    = 2'b10;
    localparam logic [1:0] EP_MASK      = EP_M1_RAGGED | EP_M2_BAD;

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    typedef struct packed {
        logic              ovf;
        logic              row_end;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/mm_result_sink_if.sv
// Multiplier-side capture bus and consumer-side drain stream.
// The drain stream carries a checksum field when MM_SINK_CKSUM_EN is defined.
interface mm_in_if;
    import mm_pkg::*;

    logic              valid;
    logic [DATA_W-1:0] data;
    logic              overflow;
    logic              change_row;
    logic [1:0]        ep;
    logic              busy;

    modport master (output valid, data, overflow, change_row, ep, busy);
    modport slave  (input  valid, data, overflow, change_row, ep, busy);
endinterface

interface mm_res_if;
    import mm_pkg::*;

    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              ovf;
    logic              row_end;
    logic              last;
    logic [GEO_W-1:0]  rows;
    logic [GEO_W-1:0]  cols;
    logic [1:0]        err;
`ifdef MM_SINK_CKSUM_EN
    logic [CKSUM_W-1:0] cksum;

    modport master (output valid, data, ovf, row_end, last, rows, cols, err, cksum, input ready);
    modport slave  (input  valid, data, ovf, row_end, last, rows, cols, err, cksum, output ready);
`else
    modport master (output valid, data, ovf, row_end, last, rows, cols, err, input ready);
    modport slave  (input  valid, data, ovf, row_end, last, rows, cols, err, output ready);
`endif
endinterface

// File: rtl/mm_result_buf.sv
// One-frame result store: DEPTH entries, one write port, one registered read port.
// A same-cycle write to the address being read is forwarded to the read register.
module mm_result_buf
    import mm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  entry_t            wr_data,
    input  logic              rd_en,
    input  logic              rd_clr,
    input  logic [ADDR_W-1:0] rd_addr,
    output entry_t            rd_data
);

    entry_t mem_q [DEPTH];
    entry_t rd_q;
    entry_t rd_d;

    // Storage write port.
    // NOTE: the array carries no reset; its contents are only read after being written.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Next read-register value: clear, load (with write forwarding) or hold.
    // NOTE: rd_d gets its hold value first so no path leaves it unassigned (no latch).
    always_comb begin
        rd_d = rd_q;
        if (rd_clr) begin
            rd_d = '0;
        end else if (rd_en) begin
            rd_d = (we && (wr_addr == rd_addr)) ? wr_data : mem_q[rd_addr];
        end
    end

    // Read register, cleared by reset so the drain outputs come up 0.
    // NOTE: rst is sampled only at the clock edge, so it stays out of the sensitivity list;
    // non-blocking assignments keep every flop updating from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    assign rd_data = rd_q;

endmodule

// File: rtl/mm_result_sink.sv
// Result sink for the matrix multiplier: captures one frame of result elements,
// tracks row/column geometry, then drains the frame on a ready/valid stream.
// Optional feature: define MM_SINK_CKSUM_EN to add a 16-bit frame checksum output.
module mm_result_sink
    import mm_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    mm_in_if.slave   mm,
    mm_res_if.master res,
    output logic     lost,
    output logic     collecting
);

    state_t            state_q, state_d;
    logic              valid_prev_q, busy_prev_q;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [GEO_W-1:0]  rows_q, rows_d;
    logic [GEO_W-1:0]  cols_q, cols_d;
    logic [1:0]        err_q, err_d;
    logic              lost_q, lost_d;
    logic              res_valid_q, res_valid_d;
    logic              res_last_q, res_last_d;
    logic [GEO_W-1:0]  res_rows_q, res_rows_d;
    logic [GEO_W-1:0]  res_cols_q, res_cols_d;
    logic [1:0]        res_err_q, res_err_d;
`ifdef MM_SINK_CKSUM_EN
    logic [CKSUM_W-1:0] cksum_q, cksum_d;
    logic [CKSUM_W-1:0] res_cksum_q, res_cksum_d;
`endif

    logic              capture, frame_end;
    logic              buf_we, buf_rd_en, buf_rd_clr;
    logic [ADDR_W-1:0] buf_rd_addr;
    entry_t            buf_wr_data, buf_rd_data;

    // A held mm_valid level counts as one element; a busy 1->0 step ends the frame.
    assign capture   = mm.valid && !valid_prev_q;
    assign frame_end = !mm.busy && busy_prev_q;

    // Capture/geometry bookkeeping plus the IDLE/COLLECT/DRAIN next-state and beat loading.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rows_d      = rows_q;
        cols_d      = cols_q;
        err_d       = err_q;
        lost_d      = lost_q;
        res_valid_d = res_valid_q;
        res_last_d  = res_last_q;
        res_rows_d  = res_rows_q;
        res_cols_d  = res_cols_q;
        res_err_d   = res_err_q;
`ifdef MM_SINK_CKSUM_EN
        cksum_d     = cksum_q;
        res_cksum_d = res_cksum_q;
`endif
        buf_we      = 1'b0;
        buf_wr_data = '{ovf: mm.overflow, row_end: mm.change_row, data: mm.data};
        buf_rd_en   = 1'b0;
        buf_rd_clr  = 1'b0;
        buf_rd_addr = rd_ptr_q[ADDR_W-1:0];

        if (capture) begin
            if (state_q == DRAIN) begin
                lost_d = 1'b1;
            end else if ((mm.ep & EP_MASK) != 2'b00) begin
                err_d = err_q | (mm.ep & EP_MASK);
            end else if (wr_ptr_q == PTR_W'(DEPTH)) begin
                lost_d = 1'b1;
            end else begin
                buf_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
                if (mm.change_row) begin
                    rows_d = rows_q + GEO_W'(1);
                    // Column count comes from the first row only.
                    if (rows_q == '0) begin
                        cols_d = GEO_W'(wr_ptr_q + PTR_W'(1));
                    end
                end
`ifdef MM_SINK_CKSUM_EN
                cksum_d = cksum_q + {{(CKSUM_W-DATA_W){mm.data[DATA_W-1]}}, mm.data};
`endif
            end
        end

        unique case (state_q)
            IDLE: begin
                if (capture) begin
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (frame_end) begin
                    // Present the first beat on the edge that ends the busy-low cycle.
                    state_d     = DRAIN;
                    res_valid_d = 1'b1;
                    res_rows_d  = rows_d;
                    res_cols_d  = cols_d;
                    res_err_d   = err_d;
                    rd_ptr_d    = '0;
                    if (wr_ptr_d == '0) begin
                        buf_rd_clr = 1'b1;
                        res_last_d = 1'b1;
                    end else begin
                        buf_rd_en   = 1'b1;
                        buf_rd_addr = '0;
                        res_last_d  = (wr_ptr_d == PTR_W'(1));
                    end
`ifdef MM_SINK_CKSUM_EN
                    res_cksum_d = res_last_d ? cksum_d : '0;
`endif
                end
            end
            DRAIN: begin
                if (res_valid_q && res.ready) begin
                    if (res_last_q) begin
                        state_d     = IDLE;
                        wr_ptr_d    = '0;
                        rd_ptr_d    = '0;
                        rows_d      = '0;
                        cols_d      = '0;
                        err_d       = '0;
                        res_valid_d = 1'b0;
                        res_last_d  = 1'b0;
                        res_rows_d  = '0;
                        res_cols_d  = '0;
                        res_err_d   = '0;
                        buf_rd_clr  = 1'b1;
`ifdef MM_SINK_CKSUM_EN
                        cksum_d     = '0;
                        res_cksum_d = '0;
`endif
                    end else begin
                        rd_ptr_d    = rd_ptr_q + PTR_W'(1);
                        buf_rd_en   = 1'b1;
                        buf_rd_addr = rd_ptr_d[ADDR_W-1:0];
                        res_last_d  = (rd_ptr_d == (wr_ptr_q - PTR_W'(1)));
`ifdef MM_SINK_CKSUM_EN
                        res_cksum_d = res_last_d ? cksum_q : '0;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, pointer, geometry and output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            valid_prev_q <= 1'b0;
            busy_prev_q  <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            rows_q       <= '0;
            cols_q       <= '0;
            err_q        <= '0;
            lost_q       <= 1'b0;
            res_valid_q  <= 1'b0;
            res_last_q   <= 1'b0;
            res_rows_q   <= '0;
            res_cols_q   <= '0;
            res_err_q    <= '0;
`ifdef MM_SINK_CKSUM_EN
            cksum_q      <= '0;
            res_cksum_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            valid_prev_q <= mm.valid;
            busy_prev_q  <= mm.busy;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            rows_q       <= rows_d;
            cols_q       <= cols_d;
            err_q        <= err_d;
            lost_q       <= lost_d;
            res_valid_q  <= res_valid_d;
            res_last_q   <= res_last_d;
            res_rows_q   <= res_rows_d;
            res_cols_q   <= res_cols_d;
            res_err_q    <= res_err_d;
`ifdef MM_SINK_CKSUM_EN
            cksum_q      <= cksum_d;
            res_cksum_q  <= res_cksum_d;
`endif
        end
    end

    mm_result_buf u_buf (
        .clk     (clk),
        .rst     (rst),
        .we      (buf_we),
        .wr_addr (wr_ptr_q[ADDR_W-1:0]),
        .wr_data (buf_wr_data),
        .rd_en   (buf_rd_en),
        .rd_clr  (buf_rd_clr),
        .rd_addr (buf_rd_addr),
        .rd_data (buf_rd_data)
    );

    assign res.valid   = res_valid_q;
    assign res.data    = buf_rd_data.data;
    assign res.ovf     = buf_rd_data.ovf;
    assign res.row_end = buf_rd_data.row_end;
    assign res.last    = res_last_q;
    assign res.rows    = res_rows_q;
    assign res.cols    = res_cols_q;
    assign res.err     = res_err_q;
`ifdef MM_SINK_CKSUM_EN
    assign res.cksum   = res_cksum_q;
`endif
    assign lost        = lost_q;
    assign collecting  = (state_q == COLLECT);

endmodule

// File: tb/tb_mm_result_sink.sv
// Self-checking bench for mm_result_sink: directed frames plus randomized frames,
// each compared against a frame-level reference model built from the capture list.
module tb_mm_result_sink;
    import mm_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic lost, collecting;

    always #5 clk = ~clk;

    mm_in_if  mm();
    mm_res_if res();

    mm_result_sink dut (
        .clk        (clk),
        .rst        (rst),
        .mm         (mm),
        .res        (res),
        .lost       (lost),
        .collecting (collecting)
    );

    typedef struct {
        logic [DATA_W-1:0] data;
        bit                ovf;
        bit                cr;
        logic [1:0]        ep;
        int                hold;
    } elem_t;

    // {data, ovf, row_end, last, rows, cols, err}
    typedef logic [26:0] beat_t;

    elem_t       stim_q[$];
    beat_t       exp_q[$];
    logic [15:0] exp_cksum;
    bit          lost_exp = 1'b0;
    int          compares = 0;
    int          mismatches = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compares++;
        assert (obs === exp) else begin
            mismatches++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t obs_beat();
        return {res.data, res.ovf, res.row_end, res.last, res.rows, res.cols, res.err};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add_elem(input logic [DATA_W-1:0] d, input bit ovf, input bit cr,
                            input logic [1:0] ep, input int hold);
        elem_t e;
        e.data = d; e.ovf = ovf; e.cr = cr; e.ep = ep; e.hold = hold;
        stim_q.push_back(e);
    endtask

    // Reference model: what the frame should look like when drained.
    task automatic build_expected();
        elem_t      kept[$];
        logic [1:0] err = 2'b00;
        int         rows = 0;
        int         cols = 0;
        exp_q.delete();
        exp_cksum = 16'd0;
        foreach (stim_q[i]) begin
            if (stim_q[i].ep != 2'b00) err |= stim_q[i].ep;
            else if (kept.size() < DEPTH) kept.push_back(stim_q[i]);
            else lost_exp = 1'b1;
        end
        foreach (kept[k]) begin
            if (kept[k].cr) begin
                if (rows == 0) cols = k + 1;
                rows++;
            end
            exp_cksum += {{4{kept[k].data[DATA_W-1]}}, kept[k].data};
        end
        if (kept.size() == 0) begin
            exp_q.push_back({12'd0, 1'b0, 1'b0, 1'b1, 5'(rows), 5'(cols), err});
        end else begin
            foreach (kept[k]) begin
                exp_q.push_back({kept[k].data, kept[k].ovf, kept[k].cr,
                                 (k == kept.size() - 1), 5'(rows), 5'(cols), err});
            end
        end
    endtask

    task automatic send_frame();
        foreach (stim_q[i]) begin
            mm.busy       = 1'b1;
            mm.valid      = 1'b1;
            mm.data       = stim_q[i].data;
            mm.overflow   = stim_q[i].ovf;
            mm.change_row = stim_q[i].cr;
            mm.ep         = stim_q[i].ep;
            repeat (stim_q[i].hold) tick();
            mm.valid = 1'b0;
            tick();
        end
        check("valid_before_end", 64'(res.valid), 64'(1'b0));
        check("collecting", 64'(collecting), 64'(1'b1));
        mm.busy = 1'b0;
        tick();
        check("valid_latency", 64'(res.valid), 64'(1'b1));
    endtask

    // mode 0: always ready; 1: ready pattern 1,0,0,1; 2: random ready
    task automatic drain(input int mode);
        int    idx = 0;
        int    cyc = 0;
        bit    stalled = 1'b0;
        bit    rdy;
        beat_t held = '0;
        beat_t obs;
        while (idx < exp_q.size() && cyc < 200) begin
            check("drain_valid", 64'(res.valid), 64'(1'b1));
            obs = obs_beat();
            if (stalled) check("stall_stable", 64'(obs), 64'(held));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: rdy = ($urandom_range(0, 2) != 0);
            endcase
            if (rdy) begin
                check($sformatf("beat%0d", idx), 64'(obs), 64'(exp_q[idx]));
`ifdef MM_SINK_CKSUM_EN
                if (idx == exp_q.size() - 1) check("cksum_last", 64'(res.cksum), 64'(exp_cksum));
                else check("cksum_zero", 64'(res.cksum), 64'(16'd0));
`endif
                idx++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                held    = obs;
            end
            res.ready = rdy;
            tick();
            cyc++;
        end
        res.ready = 1'b0;
        check("drain_complete", 64'(idx), 64'(exp_q.size()));
        check("valid_after_drain", 64'(res.valid), 64'(1'b0));
        check("collecting_after_drain", 64'(collecting), 64'(1'b0));
        check("lost", 64'(lost), 64'(lost_exp));
    endtask

    task automatic run_frame(input int mode);
        build_expected();
        send_frame();
        drain(mode);
    endtask

    task automatic frame_2x2();
        stim_q.delete();
        add_elem(12'd5, 1'b0, 1'b0, 2'b00, 1);
        add_elem(12'hFFD, 1'b0, 1'b1, 2'b00, 1);
        add_elem(12'd7, 1'b0, 1'b0, 2'b00, 1);
        add_elem(12'h7FF, 1'b0, 1'b1, 2'b00, 1);
    endtask

    task automatic gen_random();
        int n = $urandom_range(1, DEPTH);
        int c = $urandom_range(1, 4);
        stim_q.delete();
        for (int k = 0; k < n; k++) begin
            add_elem(12'($urandom), ($urandom_range(0, 7) == 0),
                     (((k + 1) % c) == 0) || (k == n - 1),
                     ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                     $urandom_range(1, 3));
        end
    endtask

    initial begin
        mm.valid = 1'b0; mm.data = '0; mm.overflow = 1'b0;
        mm.change_row = 1'b0; mm.ep = 2'b00; mm.busy = 1'b0;
        res.ready = 1'b0;

        // Reset state
        rst = 1'b0;
        repeat (3) tick();
        check("rst_valid", 64'(res.valid), 64'(1'b0));
        check("rst_outputs", 64'(obs_beat()), 64'(0));
        check("rst_lost", 64'(lost), 64'(1'b0));
        check("rst_collecting", 64'(collecting), 64'(1'b0));
`ifdef MM_SINK_CKSUM_EN
        check("rst_cksum", 64'(res.cksum), 64'(16'd0));
`endif
        rst = 1'b1;
        tick();

        // Frame end seen in IDLE is ignored
        mm.busy = 1'b1; tick();
        mm.busy = 1'b0; tick(); tick();
        check("idle_frame_end_valid", 64'(res.valid), 64'(1'b0));
        check("idle_frame_end_collecting", 64'(collecting), 64'(1'b0));

        // 2x2 frame, continuous ready
        frame_2x2();
        run_frame(0);

        // Error-only frame
        stim_q.delete();
        add_elem(12'h123, 1'b0, 1'b0, 2'b10, 1);
        run_frame(0);

        // Overflow flag on a single element
        stim_q.delete();
        add_elem(12'd1, 1'b0, 1'b0, 2'b00, 1);
        add_elem(12'h7FF, 1'b1, 1'b0, 2'b00, 1);
        add_elem(12'd3, 1'b0, 1'b1, 2'b00, 2);
        run_frame(0);

        // 2x2 frame with stalling consumer
        frame_2x2();
        run_frame(1);

        // Capture during DRAIN is dropped and sets lost
        frame_2x2();
        build_expected();
        send_frame();
        mm.valid = 1'b1; mm.data = 12'h055; mm.ep = 2'b00;
        tick();
        mm.valid = 1'b0;
        tick();
        lost_exp = 1'b1;
        check("lost_drain_capture", 64'(lost), 64'(1'b1));
        drain(0);

        // Overfull frame: 17 captures, 16 stored
        stim_q.delete();
        for (int k = 0; k < DEPTH + 1; k++) add_elem(12'(k * 37 - 200), 1'b0, (k % 4) == 3, 2'b00, 1);
        run_frame(2);

        // lost stays set across the next frame
        frame_2x2();
        run_frame(0);

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            gen_random();
            run_frame(2);
        end

        // Reset during beat 2 of a drain
        frame_2x2();
        build_expected();
        send_frame();
        res.ready = 1'b1;
        tick();
        res.ready = 1'b0;
        check("beat2_before_reset", 64'(obs_beat()), 64'(exp_q[1]));
        rst = 1'b0;
        tick();
        check("midrst_valid", 64'(res.valid), 64'(1'b0));
        check("midrst_outputs", 64'(obs_beat()), 64'(0));
        check("midrst_lost", 64'(lost), 64'(1'b0));
        check("midrst_collecting", 64'(collecting), 64'(1'b0));
`ifdef MM_SINK_CKSUM_EN
        check("midrst_cksum", 64'(res.cksum), 64'(16'd0));
`endif
        rst = 1'b1;
        lost_exp = 1'b0;
        tick();

        // 1x1 frame after reset
        stim_q.delete();
        add_elem(12'hF00, 1'b0, 1'b1, 2'b00, 1);
        run_frame(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, mismatches);
        $finish;
    end

endmodule
